stream_unpacker: RTL and testbench

//   Width downsizer for vld/rdy streams. Accepts one IN_WIDTH word per handshake and

---
 rtl/stream_unpacker.sv | 107 ++++++++++
 tb/tb_stream_unpacker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : stream_unpacker
// Purpose  : Width downsizer for vld/rdy streams. Takes one IN_WIDTH word per
//            handshake and emits up to RATIO OUT_WIDTH beats, least-significant
//            slice first, flagging the final beat of each word with last_out.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            vld_in, rdy_in   - upstream word handshake
//            data_in          - upstream word, beat k = data_in[k*OUT_WIDTH +: OUT_WIDTH]
//            nbeats_in        - valid beats in data_in (values > RATIO clamp to RATIO)
//            data_out, vld_out, last_out - registered downstream beat
//            rdy_out          - downstream accepts beat
//            busy             - a word is held with beats remaining
// Revision : 1.0 - initial release
// ============================================================================
module stream_unpacker #(
  parameter int OUT_WIDTH = 16,
  parameter int RATIO     = 4,
  parameter int IN_WIDTH  = OUT_WIDTH * RATIO,
  parameter int CNT_WIDTH = $clog2(RATIO) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic [CNT_WIDTH-1:0] nbeats_in,
  output logic                 rdy_in,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 vld_out,
  output logic                 last_out,
  input  logic                 rdy_out,
  output logic                 busy
);

  localparam int IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  logic [IN_WIDTH-1:0]  hold;
  logic [IDX_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] n;

  logic [OUT_WIDTH-1:0] hold_beat [RATIO];
  logic [CNT_WIDTH-1:0] n_clamp;
  logic                 accept;
  logic                 load;
  logic [IDX_WIDTH-1:0] idx_next;
  logic                 next_is_last;

  generate
    for (genvar k = 0; k < RATIO; k++) begin : g_beats
      assign hold_beat[k] = hold[k*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign n_clamp = (nbeats_in > CNT_WIDTH'(RATIO)) ? CNT_WIDTH'(RATIO) : nbeats_in;

  // rdy_out feeds rdy_in combinationally so a new word can be loaded on the
  // same edge the previous word's last beat leaves: no bubble between words.
  assign rdy_in = rst_n && ((state == IDLE) || (vld_out && rdy_out && last_out));
  assign accept = vld_in && rdy_in;
  // A zero-beat word is still consumed, it simply produces no output.
  assign load   = accept && (n_clamp != '0);

  assign idx_next     = idx + 1'b1;
  assign next_is_last = ((CNT_WIDTH'(idx) + CNT_WIDTH'(2)) == n);

  assign busy = vld_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      idx      <= '0;
      n        <= '0;
      data_out <= '0;
      vld_out  <= 1'b0;
      last_out <= 1'b0;
    end else if ((state == IDLE) || (rdy_out && last_out)) begin
      // Word boundary: either nothing held, or the final beat is leaving now.
      if (load) begin
        state    <= SEND;
        hold     <= data_in;
        n        <= n_clamp;
        idx      <= '0;
        data_out <= data_in[OUT_WIDTH-1:0];
        vld_out  <= 1'b1;
        last_out <= (n_clamp == CNT_WIDTH'(1));
      end else if (state == SEND) begin
        // data_out keeps its stale value; only the valid flags drop.
        state    <= IDLE;
        vld_out  <= 1'b0;
        last_out <= 1'b0;
      end
    end else if (rdy_out) begin
      idx      <= idx_next;
      data_out <= hold_beat[idx_next];
      last_out <= next_is_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_unpacker
// Purpose  : Self-checking bench for stream_unpacker (OUT_WIDTH=16, RATIO=4).
//            Directed scenarios plus a randomized backpressure run scored
//            against a queue of expected beats derived from each input word.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_unpacker;

  localparam int OW = 16;
  localparam int RT = 4;
  localparam int IW = OW * RT;
  localparam int CW = $clog2(RT) + 1;
  localparam int NWORDS = 100;

  logic          clk;
  logic          rst_n;
  logic          vld_in;
  logic [IW-1:0] data_in;
  logic [CW-1:0] nbeats_in;
  logic          rdy_in;
  logic [OW-1:0] data_out;
  logic          vld_out;
  logic          last_out;
  logic          rdy_out;
  logic          busy;

  int errors = 0;
  int checks = 0;

  stream_unpacker #(
    .OUT_WIDTH(OW),
    .RATIO    (RT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .nbeats_in(nbeats_in),
    .rdy_in   (rdy_in),
    .data_out (data_out),
    .vld_out  (vld_out),
    .last_out (last_out),
    .rdy_out  (rdy_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vld_in = 1'b0; rdy_out = 1'b1; data_in = '0; nbeats_in = '0;
    tick();
    tick();
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b expected 0", vld_out); end
    checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", last_out); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL rst_data: got %h expected 0000", data_out); end
    checks++; if (rdy_in !== 1'b0) begin errors++; $display("FAIL rst_rdy_in: got %b expected 0", rdy_in); end
    rst_n = 1'b1;
    #1;
    checks++; if (rdy_in !== 1'b1) begin errors++; $display("FAIL rst_release_rdy_in: got %b expected 1", rdy_in); end
    tick();
  endtask

  task automatic test_single();
    logic [IW-1:0] w;
    w = 64'h4444_3333_2222_1111;
    rdy_out = 1'b1; data_in = w; nbeats_in = 3'd4; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL single_vld[%0d]: got %b expected 1", k, vld_out); end
      checks++; if (data_out !== w[k*OW +: OW]) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, data_out, w[k*OW +: OW]); end
      checks++; if (last_out !== (k == 3)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", k, last_out, (k == 3)); end
      checks++; if (rdy_in !== (k == 3)) begin errors++; $display("FAIL single_rdy_in[%0d]: got %b expected %b", k, rdy_in, (k == 3)); end
      tick();
    end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", vld_out); end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] w0, w1;
    logic [OW-1:0] exp_beat;
    w0 = {$urandom(), $urandom()};
    w1 = {$urandom(), $urandom()};
    rdy_out = 1'b1; data_in = w0; nbeats_in = 3'd4; vld_in = 1'b1;
    tick();
    data_in = w1;
    for (int k = 0; k < 8; k++) begin
      exp_beat = (k < 4) ? w0[k*OW +: OW] : w1[(k-4)*OW +: OW];
      checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d]: got %b expected 1", k, vld_out); end
      checks++; if (data_out !== exp_beat) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, data_out, exp_beat); end
      checks++; if (last_out !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", k, last_out, (k % 4 == 3)); end
      if (k == 3) begin
        checks++; if (rdy_in !== 1'b1) begin errors++; $display("FAIL b2b_rdy_in: got %b expected 1", rdy_in); end
      end
      tick();
      if (k == 3) vld_in = 1'b0;
    end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", vld_out); end
  endtask

  task automatic test_partial_zero();
    logic [IW-1:0] wa, wb, wc;
    wa = {$urandom(), $urandom()};
    wb = {$urandom(), $urandom()};
    wc = {$urandom(), $urandom()};
    rdy_out = 1'b1;
    data_in = wa; nbeats_in = 3'd2; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (vld_out !== 1'b1 || data_out !== wa[k*OW +: OW] || last_out !== (k == 1)) begin
        errors++; $display("FAIL partial2_beat[%0d]: got vld=%b data=%h last=%b expected vld=1 data=%h last=%b",
                           k, vld_out, data_out, last_out, wa[k*OW +: OW], (k == 1));
      end
      tick();
    end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL partial2_end: got %b expected 0", vld_out); end
    data_in = wb; nbeats_in = 3'd0; vld_in = 1'b1;
    #1;
    checks++; if (rdy_in !== 1'b1) begin errors++; $display("FAIL zero_rdy_in: got %b expected 1", rdy_in); end
    tick();
    vld_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL zero_no_output[%0d]: got %b expected 0", k, vld_out); end
      tick();
    end
    data_in = wc; nbeats_in = 3'd7; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (vld_out !== 1'b1 || data_out !== wc[k*OW +: OW] || last_out !== (k == 3)) begin
        errors++; $display("FAIL clamp_beat[%0d]: got vld=%b data=%h last=%b expected vld=1 data=%h last=%b",
                           k, vld_out, data_out, last_out, wc[k*OW +: OW], (k == 3));
      end
      tick();
    end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL clamp_end: got %b expected 0", vld_out); end
  endtask

  task automatic test_backpressure();
    logic [OW:0]   exp_q[$];
    logic [IW-1:0] cur_word;
    int            cur_nb;
    int            nb_eff;
    int            wi;
    int            cyc;
    logic          prev_stall;
    logic [OW-1:0] prev_data;
    logic          prev_last;
    logic          out_fire;
    logic          in_fire;
    logic          exp_rdy_in;
    wi = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    cur_word = '0; cur_nb = 0;
    vld_in = 1'b0; rdy_out = 1'b0;
    while (!(wi == NWORDS && exp_q.size() == 0 && !vld_in) && cyc < 4000) begin
      checks++; if (vld_out !== (exp_q.size() != 0) || busy !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL bp_vld: got vld=%b busy=%b expected %b", vld_out, busy, (exp_q.size() != 0));
      end
      if (vld_out && exp_q.size() != 0) begin
        checks++; if ({last_out, data_out} !== exp_q[0]) begin
          errors++; $display("FAIL bp_beat: got last=%b data=%h expected last=%b data=%h",
                             last_out, data_out, exp_q[0][OW], exp_q[0][OW-1:0]);
        end
      end
      if (prev_stall) begin
        checks++; if (vld_out !== 1'b1 || data_out !== prev_data || last_out !== prev_last) begin
          errors++; $display("FAIL bp_hold: got vld=%b data=%h last=%b expected vld=1 data=%h last=%b",
                             vld_out, data_out, last_out, prev_data, prev_last);
        end
      end
      if (!vld_in && wi < NWORDS && $urandom_range(0, 3) != 0) begin
        cur_word  = {$urandom(), $urandom()};
        cur_nb    = $urandom_range(0, 7);
        data_in   = cur_word;
        nbeats_in = CW'(cur_nb);
        vld_in    = 1'b1;
      end
      rdy_out = 1'($urandom_range(0, 1));
      #1;
      exp_rdy_in = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy_out);
      checks++; if (rdy_in !== exp_rdy_in) begin
        errors++; $display("FAIL bp_rdy_in: got %b expected %b", rdy_in, exp_rdy_in);
      end
      out_fire   = vld_out && rdy_out;
      in_fire    = vld_in && rdy_in;
      prev_stall = vld_out && !rdy_out;
      prev_data  = data_out;
      prev_last  = last_out;
      tick();
      if (out_fire && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_fire) begin
        nb_eff = (cur_nb > RT) ? RT : cur_nb;
        for (int k = 0; k < nb_eff; k++) exp_q.push_back({(k == nb_eff - 1), cur_word[k*OW +: OW]});
        wi++;
        vld_in = 1'b0;
      end
      cyc++;
    end
    checks++; if (cyc >= 4000) begin errors++; $display("FAIL bp_timeout: got %0d words sent expected %0d", wi, NWORDS); end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL bp_final_idle: got %b expected 0", vld_out); end
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] w, w2;
    w  = {$urandom(), $urandom()};
    w2 = {$urandom(), $urandom()};
    rdy_out = 1'b1; data_in = w; nbeats_in = 3'd4; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    checks++; if (vld_out !== 1'b1 || data_out !== w[OW-1:0]) begin
      errors++; $display("FAIL mid_beat0: got vld=%b data=%h expected vld=1 data=%h", vld_out, data_out, w[OW-1:0]);
    end
    tick();
    checks++; if (vld_out !== 1'b1 || data_out !== w[OW +: OW]) begin
      errors++; $display("FAIL mid_beat1: got vld=%b data=%h expected vld=1 data=%h", vld_out, data_out, w[OW +: OW]);
    end
    rst_n = 1'b0;
    tick();
    checks++; if (vld_out !== 1'b0 || last_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset_out: got vld=%b last=%b expected 0 0", vld_out, last_out);
    end
    checks++; if (rdy_in !== 1'b0) begin errors++; $display("FAIL mid_reset_rdy_in: got %b expected 0", rdy_in); end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL mid_no_beats[%0d]: got %b expected 0", k, vld_out); end
    end
    data_in = w2; nbeats_in = 3'd2; vld_in = 1'b1;
    #1;
    checks++; if (rdy_in !== 1'b1) begin errors++; $display("FAIL mid_next_rdy_in: got %b expected 1", rdy_in); end
    tick();
    vld_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (vld_out !== 1'b1 || data_out !== w2[k*OW +: OW] || last_out !== (k == 1)) begin
        errors++; $display("FAIL mid_next_beat[%0d]: got vld=%b data=%h last=%b expected vld=1 data=%h last=%b",
                           k, vld_out, data_out, last_out, w2[k*OW +: OW], (k == 1));
      end
      tick();
    end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL mid_next_end: got %b expected 0", vld_out); end
  endtask

  initial begin
    rst_n = 1'b0; vld_in = 1'b0; data_in = '0; nbeats_in = '0; rdy_out = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_partial_zero();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
